// File: rtl/rv_instr_encoder.sv
// rv_instr_encoder
//   Streaming RV32I instruction encoder. Packs decoded fields into a 32-bit
//   instruction word (the inverse of the core's decode path). The word is
//   encoded combinationally at the input and registered into a 2-entry skid
//   buffer, so in_ready is a pure flop output with no path from out_ready.
// Ports
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   input handshake for one field bundle
//   in_opcode..in_imm   decoded fields (imm in byte-offset form)
//   out_valid/out_ready output handshake
//   out_instr           encoded word (0 for an unknown opcode)
//   out_illegal         opcode was not a legal RV32I base opcode
//   emit_count          saturating count of words handed off
//   illegal_count       saturating count of illegal words handed off
module rv_instr_encoder #(
  parameter int COUNT_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [6:0]         in_opcode,
  input  logic [4:0]         in_rd,
  input  logic [4:0]         in_rs1,
  input  logic [4:0]         in_rs2,
  input  logic [2:0]         in_funct3,
  input  logic [6:0]         in_funct7,
  input  logic [31:0]        in_imm,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_instr,
  output logic               out_illegal,
  output logic [COUNT_W-1:0] emit_count,
  output logic [COUNT_W-1:0] illegal_count
);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // Main (M) entry drives the outputs, skid (S) entry absorbs one bundle
  // accepted while M is stalled.
  logic               m_valid_q, m_valid_d;
  logic [31:0]        m_instr_q, m_instr_d;
  logic               m_illegal_q, m_illegal_d;
  logic               s_valid_q, s_valid_d;
  logic [31:0]        s_instr_q, s_instr_d;
  logic               s_illegal_q, s_illegal_d;
  logic [COUNT_W-1:0] emit_q, emit_d;
  logic [COUNT_W-1:0] ill_q, ill_d;

  logic [31:0] enc_instr;
  logic        enc_illegal;
  logic        accept, drain;

  // Field packing
  always_comb begin
    enc_instr   = 32'h0;
    enc_illegal = 1'b0;
    case (in_opcode)
      OPC_OP:
        enc_instr = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      OPC_OP_IMM, OPC_JALR, OPC_LOAD:
        enc_instr = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
      OPC_STORE:
        enc_instr = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
      OPC_BRANCH:
        enc_instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                     in_imm[4:1], in_imm[11], in_opcode};
      OPC_LUI, OPC_AUIPC:
        enc_instr = {in_imm[31:12], in_rd, in_opcode};
      OPC_JAL:
        enc_instr = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
      default:
        enc_illegal = 1'b1;
    endcase
  end

  assign in_ready      = !s_valid_q;
  assign out_valid     = m_valid_q;
  assign out_instr     = m_instr_q;
  assign out_illegal   = m_illegal_q;
  assign emit_count    = emit_q;
  assign illegal_count = ill_q;

  assign accept = in_valid && in_ready;
  assign drain  = m_valid_q && out_ready;

  // Skid buffer and counters
  always_comb begin
    m_valid_d   = m_valid_q;
    m_instr_d   = m_instr_q;
    m_illegal_d = m_illegal_q;
    s_valid_d   = s_valid_q;
    s_instr_d   = s_instr_q;
    s_illegal_d = s_illegal_q;
    emit_d      = emit_q;
    ill_d       = ill_q;

    if (drain) begin
      if (s_valid_q) begin
        m_instr_d   = s_instr_q;
        m_illegal_d = s_illegal_q;
        s_valid_d   = 1'b0;
      end else begin
        m_valid_d   = 1'b0;
      end
      if (emit_q != '1) emit_d = emit_q + COUNT_W'(1);
      if (m_illegal_q && ill_q != '1) ill_d = ill_q + COUNT_W'(1);
    end

    // accept implies S empty, so a drain above never loads M from S here
    if (accept) begin
      if (!m_valid_q || drain) begin
        m_valid_d   = 1'b1;
        m_instr_d   = enc_instr;
        m_illegal_d = enc_illegal;
      end else begin
        s_valid_d   = 1'b1;
        s_instr_d   = enc_instr;
        s_illegal_d = enc_illegal;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_q   <= 1'b0;
      m_instr_q   <= 32'h0;
      m_illegal_q <= 1'b0;
      s_valid_q   <= 1'b0;
      s_instr_q   <= 32'h0;
      s_illegal_q <= 1'b0;
      emit_q      <= '0;
      ill_q       <= '0;
    end else begin
      m_valid_q   <= m_valid_d;
      m_instr_q   <= m_instr_d;
      m_illegal_q <= m_illegal_d;
      s_valid_q   <= s_valid_d;
      s_instr_q   <= s_instr_d;
      s_illegal_q <= s_illegal_d;
      emit_q      <= emit_d;
      ill_q       <= ill_d;
    end
  end

endmodule

// File: tb/tb_rv_instr_encoder.sv
module tb_rv_instr_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [6:0]  in_opcode = '0;
  logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [2:0]  in_funct3 = '0;
  logic [6:0]  in_funct7 = '0;
  logic [31:0] in_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic        out_illegal;
  logic [31:0] emit_count, illegal_count;

  // narrow-counter instance sharing the same stimulus, to exercise saturation
  logic        in_ready2, out_valid2, out_illegal2;
  logic [31:0] out_instr2;
  logic [1:0]  emit_count2, illegal_count2;

  always #5 clk = ~clk;

  rv_instr_encoder #(.COUNT_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_illegal(out_illegal), .emit_count(emit_count), .illegal_count(illegal_count));

  rv_instr_encoder #(.COUNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid2), .out_ready(out_ready), .out_instr(out_instr2),
    .out_illegal(out_illegal2), .emit_count(emit_count2), .illegal_count(illegal_count2));

  int n_checks = 0;
  int n_fail   = 0;
  logic [32:0] exp_q[$];       // {illegal, word}, FIFO of accepted bundles
  int unsigned exp_emit = 0;
  int unsigned exp_ill  = 0;
  logic        acc_flag = 1'b0;
  logic [6:0]  legal_ops [9] = '{7'h33, 7'h13, 7'h67, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference encoder: fields are shifted into place with plain arithmetic.
  function automatic logic [32:0] ref_enc(input logic [6:0] opc, input logic [4:0] rd,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
      input logic [6:0] f7, input logic [31:0] imm);
    int unsigned o, w, im;
    o  = 32'(opc);
    im = imm;
    case (o)
      32'h33: w = o | 32'(rd) << 7 | 32'(f3) << 12 | 32'(rs1) << 15 | 32'(rs2) << 20 | 32'(f7) << 25;
      32'h13, 32'h67, 32'h03:
        w = o | 32'(rd) << 7 | 32'(f3) << 12 | 32'(rs1) << 15 | (im % 4096) << 20;
      32'h23: w = o | (im % 32) << 7 | 32'(f3) << 12 | 32'(rs1) << 15 | 32'(rs2) << 20
                  | ((im / 32) % 128) << 25;
      32'h63: w = o | ((im / 2048) % 2) << 7 | ((im / 2) % 16) << 8 | 32'(f3) << 12
                  | 32'(rs1) << 15 | 32'(rs2) << 20 | ((im / 32) % 64) << 25
                  | ((im / 4096) % 2) << 31;
      32'h37, 32'h17: w = o | 32'(rd) << 7 | (im / 4096) * 4096;
      32'h6F: w = o | 32'(rd) << 7 | ((im / 4096) % 256) << 12 | ((im / 2048) % 2) << 20
                  | ((im / 2) % 1024) << 21 | ((im / 1048576) % 2) << 31;
      default: return {1'b1, 32'h0};
    endcase
    return {1'b0, w};
  endfunction

  // One clock: check outputs against the model at the falling edge, then
  // record any handshake that the next rising edge will perform.
  task automatic step();
    logic drn;
    logic [32:0] e;
    int unsigned sat2;
    @(negedge clk);
    chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
    chk("in_ready", 64'(in_ready), 64'(exp_q.size() < 2));
    chk("emit_count", 64'(emit_count), 64'(exp_emit));
    chk("illegal_count", 64'(illegal_count), 64'(exp_ill));
    sat2 = (exp_emit > 3) ? 3 : exp_emit;
    chk("emit_count_sat", 64'(emit_count2), 64'(sat2));
    sat2 = (exp_ill > 3) ? 3 : exp_ill;
    chk("illegal_count_sat", 64'(illegal_count2), 64'(sat2));
    acc_flag = in_valid && in_ready;
    drn = out_valid && out_ready;
    if (drn && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("out_instr", 64'(out_instr), 64'(e[31:0]));
      chk("out_illegal", 64'(out_illegal), 64'(e[32]));
      exp_emit++;
      if (e[32]) exp_ill++;
    end
    if (acc_flag)
      exp_q.push_back(ref_enc(in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm));
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [6:0] opc, input logic [4:0] rd, input logic [4:0] rs1,
      input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm);
    in_opcode = opc; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm;
    in_valid = 1'b1;
    acc_flag = 1'b0;
    for (int i = 0; i < 100 && !acc_flag; i++) step();
    chk("send_accepted", 64'(acc_flag), 64'(1));
  endtask

  task automatic rand_fields();
    in_opcode = ($urandom_range(0, 9) == 0) ? 7'($urandom) : legal_ops[$urandom_range(0, 8)];
    in_rd = 5'($urandom); in_rs1 = 5'($urandom); in_rs2 = 5'($urandom);
    in_funct3 = 3'($urandom); in_funct7 = 7'($urandom); in_imm = $urandom;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    exp_emit = 0; exp_ill = 0;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_out_instr", 64'(out_instr), 64'(0));
    chk("rst_out_illegal", 64'(out_illegal), 64'(0));
    chk("rst_emit", 64'(emit_count), 64'(0));
    chk("rst_illegal", 64'(illegal_count), 64'(0));
  endtask

  initial begin
    int unsigned base;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // 1: ADD, visible right after the accepting edge
    out_ready = 1'b1;
    send(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    in_valid = 1'b0;
    chk("t1_add", 64'(out_instr), 64'h002081B3);
    chk("t1_valid", 64'(out_valid), 64'(1));
    step();

    // 2: back-to-back ADDI, LUI, JAL
    base = exp_emit;
    send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    chk("t2_addi", 64'(out_instr), 64'h00500093);
    send(7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000);
    chk("t2_lui", 64'(out_instr), 64'h123452B7);
    send(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8);
    chk("t2_jal", 64'(out_instr), 64'h008000EF);
    in_valid = 1'b0;
    step();
    chk("t2_emit", 64'(emit_count), 64'(base + 3));

    // 3: stall fills both entries, then drains in order
    out_ready = 1'b0;
    send(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd16);
    send(7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd4);
    in_valid = 1'b0;
    chk("t3_in_ready_low", 64'(in_ready), 64'(0));
    chk("t3_beq_held", 64'(out_instr), 64'h00208863);
    step();
    chk("t3_beq_still", 64'(out_instr), 64'h00208863);
    out_ready = 1'b1;
    step();
    chk("t3_sw", 64'(out_instr), 64'h0020A223);
    step();

    // 4: illegal opcode, then a normal ADD
    base = exp_ill;
    send(7'h7F, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFFFFFF);
    chk("t4_ill_instr", 64'(out_instr), 64'(0));
    chk("t4_ill_flag", 64'(out_illegal), 64'(1));
    send(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    in_valid = 1'b0;
    chk("t4_ill_count", 64'(illegal_count), 64'(base + 1));
    chk("t4_add", 64'(out_instr), 64'h002081B3);
    chk("t4_add_flag", 64'(out_illegal), 64'(0));
    step();

    // 5: reset with both entries full
    out_ready = 1'b0;
    send(7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd7);
    send(7'h13, 5'd2, 5'd3, 5'd0, 3'd0, 7'd0, 32'd9);
    chk("t5_full", 64'(in_ready), 64'(0));
    do_reset();

    // 6: random streams with random backpressure
    acc_flag = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid || acc_flag) begin
        in_valid = ($urandom_range(0, 3) != 0);
        if (in_valid) rand_fields();
      end
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();
    chk("drain_empty", 64'(exp_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
